pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
- Sequences the program counter and the instruction-fetch bus for the IF stage.
- Arbitrates the redirect sources (trap, mret, EX branch, ID jump) by fixed priority.
- Keeps at most one fetch outstanding and squashes responses made stale by a redirect.
- Buffers the returned instruction while IF/ID is stalled, then advances PC by 4.

Parameters:
- XLEN, 32, PC and bus address width.
- BOOT_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-low.
- if2id_stall  in  1  IF/ID cannot accept an instruction this cycle.
- trap_valid  in  1  trap redirect request.
- trap_pc  in  XLEN  trap target (mtvec).
- mret_valid  in  1  mret redirect request.
- mret_pc  in  XLEN  mret target (mepc).
- branch_valid  in  1  EX taken-branch redirect.
- branch_pc  in  XLEN  branch target.
- jump_valid  in  1  ID jump redirect.
- jump_pc  in  XLEN  jump target.
- ifetch_req  out  1  fetch request.
- ifetch_addr  out  XLEN  fetch address (= current PC).
- ifetch_ready  in  1  request accepted this cycle.
- ifetch_rvalid  in  1  response valid.
- ifetch_rdata  in  32  response instruction.
- if_inst_valid  out  1  buffered instruction valid to IF/ID.
- if_inst  out  32  buffered instruction.
- if_pc  out  XLEN  PC of if_inst.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - state=BOOT, pc=BOOT_PC
  - ifetch_req=0, if_inst_valid=0, if_inst=0, if_pc=BOOT_PC
  - Asserting reset mid-transaction abandons any outstanding fetch; after release the bus owner must not deliver a stale rvalid.
- Redirect arbitration (combinational), priority trap > mret > branch > jump:
  - redirect = OR of all *_valid.
  - target = selected pc with bits [1:0] forced to 0.
- PC arithmetic: pc+4 wraps modulo 2^XLEN.
- ifetch_addr=pc at all times. ifetch_req=1 only in REQ.
- While req=1 and ready=0, the address may change on a redirect; the bus samples it only when ready=1.
- States and transitions:
  - BOOT: ifetch_req=0. Next cycle -> REQ. A redirect here loads pc<=target.
  - REQ:
    - ready=1, no redirect -> WAIT.
    - ready=0 with redirect -> pc<=target, stay REQ.
    - ready=1 with redirect (old address accepted) -> pc<=target, DROP.
  - WAIT (one request outstanding):
    - rvalid=1, no redirect -> capture if_inst<=rdata, if_pc<=pc, if_inst_valid<=1 -> HOLD.
    - redirect with rvalid=1 -> discard data, pc<=target -> REQ.
    - redirect with rvalid=0 -> pc<=target -> DROP.
  - DROP: waits for the squashed response.
    - rvalid=1 -> discard -> REQ.
    - Redirects here update pc<=target (latest wins); stay DROP.
  - HOLD: if_inst_valid=1, data stable.
    - redirect -> if_inst_valid<=0, pc<=target -> REQ.
    - Else if2id_stall=0 -> instruction consumed this cycle; if_inst_valid<=0, pc<=pc+4 -> REQ.
    - Else (stalled) -> hold.
- Latency and throughput:
  - Accept to if_inst_valid: 1 cycle after rvalid.
  - Sustained rate with zero-wait memory: 1 instruction per 3 cycles.
- Simultaneous redirects in the same cycle: only the highest priority takes effect; the others are dropped. Upstream must re-assert them if still needed.
- No discarded response ever produces if_inst_valid.

Decomposition:
- Shared header veririscv_core.vh:
  - PC_RANGE
  - 2-bit state encodings: FETCH_BOOT=0, FETCH_REQ=1, FETCH_WAIT=2, FETCH_DROP=3
  - HOLD encoding: widen the state to 3 bits and add FETCH_HOLD=4 in the same header.
- One natural sub-module: pc_redirect_mux, the combinational priority select producing redirect and aligned target.

Test Plan:
- Reset release, ready=1, rvalid one cycle after accept, stall=0 → addresses 0x0, 0x4, 0x8 each on a 3-cycle cadence; if_pc matches each.
- Hold: response at pc=0x4 with if2id_stall=1 for 3 cycles → if_inst_valid=1, if_inst/if_pc stable for 3 cycles; pc becomes 0x8 the cycle after stall drops.
- Redirect while outstanding: branch_pc=0x100 asserted in WAIT with rvalid=0 → DROP; the next rvalid is discarded (if_inst_valid stays 0); the next request issues to 0x100.
- Priority: trap_pc=0x80, mret_pc=0x90, branch_pc=0x100, jump_pc=0x200 all in the same cycle → next ifetch_addr=0x80. Misaligned jump_pc=0x203 alone → 0x200.
- Wrap: BOOT_PC=0xFFFF_FFFC → the second fetch address is 0x0000_0000.
- Async reset: rst pulled low mid-WAIT, between clock edges → outputs go to reset values immediately. After release, the first request is issued to BOOT_PC.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types for the IF-stage fetch controller: the fetch state encoding
// and the PC increment between sequential instructions.
package pc_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH_BOOT = 3'd0,
        FETCH_REQ  = 3'd1,
        FETCH_WAIT = 3'd2,
        FETCH_DROP = 3'd3,
        FETCH_HOLD = 3'd4
    } fetch_state_e;

    localparam int unsigned PC_STEP = 32'd4;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-fetch bus: single request/accept handshake plus a response beat.
interface pc_fetch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            ifetch_req;
    logic [XLEN-1:0] ifetch_addr;
    logic            ifetch_ready;
    logic            ifetch_rvalid;
    logic [31:0]     ifetch_rdata;

    modport master (
        output ifetch_req,
        output ifetch_addr,
        input  ifetch_ready,
        input  ifetch_rvalid,
        input  ifetch_rdata
    );

    modport slave (
        input  ifetch_req,
        input  ifetch_addr,
        output ifetch_ready,
        output ifetch_rvalid,
        output ifetch_rdata
    );
endinterface

// File: rtl/pc_redirect_mux.sv
// Fixed-priority redirect select (trap > mret > branch > jump); the chosen
// target is forced to a word boundary.
module pc_redirect_mux #(
    parameter int XLEN = 32
) (
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic            mret_valid_i,
    input  logic [XLEN-1:0] mret_pc_i,
    input  logic            branch_valid_i,
    input  logic [XLEN-1:0] branch_pc_i,
    input  logic            jump_valid_i,
    input  logic [XLEN-1:0] jump_pc_i,
    output logic            redirect_o,
    output logic [XLEN-1:0] target_o
);
    logic [XLEN-1:0] sel_pc;

    // Priority select of the raw target address
    always_comb begin
        sel_pc = {XLEN{1'b0}};
        if (trap_valid_i) begin
            sel_pc = trap_pc_i;
        end else if (mret_valid_i) begin
            sel_pc = mret_pc_i;
        end else if (branch_valid_i) begin
            sel_pc = branch_pc_i;
        end else if (jump_valid_i) begin
            sel_pc = jump_pc_i;
        end else begin
            sel_pc = {XLEN{1'b0}};
        end
    end

    assign redirect_o = trap_valid_i | mret_valid_i | branch_valid_i | jump_valid_i;
    assign target_o   = {sel_pc[XLEN-1:2], 2'b00};
endmodule

// File: rtl/pc_fetch_ctrl.sv
// IF-stage controller: issues one fetch at a time, squashes responses made
// stale by a redirect, and holds the returned instruction until IF/ID takes it.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] BOOT_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_fetch_ctrl_if.master      bus,
    input  logic                 if2id_stall_i,
    input  logic                 trap_valid_i,
    input  logic [XLEN-1:0]      trap_pc_i,
    input  logic                 mret_valid_i,
    input  logic [XLEN-1:0]      mret_pc_i,
    input  logic                 branch_valid_i,
    input  logic [XLEN-1:0]      branch_pc_i,
    input  logic                 jump_valid_i,
    input  logic [XLEN-1:0]      jump_pc_i,
    output logic                 if_inst_valid_o,
    output logic [31:0]          if_inst_o,
    output logic [XLEN-1:0]      if_pc_o
);
    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            inst_valid_q, inst_valid_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            redirect;
    logic [XLEN-1:0] target;

    pc_redirect_mux #(.XLEN(XLEN)) u_redirect_mux (
        .trap_valid_i   (trap_valid_i),
        .trap_pc_i      (trap_pc_i),
        .mret_valid_i   (mret_valid_i),
        .mret_pc_i      (mret_pc_i),
        .branch_valid_i (branch_valid_i),
        .branch_pc_i    (branch_pc_i),
        .jump_valid_i   (jump_valid_i),
        .jump_pc_i      (jump_pc_i),
        .redirect_o     (redirect),
        .target_o       (target)
    );

    // Next-state and datapath updates of the fetch sequencer
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        case (state_q)
            FETCH_BOOT: begin
                state_d = FETCH_REQ;
                if (redirect) pc_d = target;
                else          pc_d = pc_q;
            end
            FETCH_REQ: begin
                // The bus only latches the address on ready, so an unaccepted
                // request can simply retarget; an accepted one must be drained.
                if (redirect) begin
                    pc_d = target;
                    if (bus.ifetch_ready) state_d = FETCH_DROP;
                    else                  state_d = FETCH_REQ;
                end else if (bus.ifetch_ready) begin
                    state_d = FETCH_WAIT;
                end else begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_WAIT: begin
                if (redirect) begin
                    pc_d = target;
                    if (bus.ifetch_rvalid) state_d = FETCH_REQ;
                    else                   state_d = FETCH_DROP;
                end else if (bus.ifetch_rvalid) begin
                    inst_d       = bus.ifetch_rdata;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    state_d      = FETCH_HOLD;
                end else begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_DROP: begin
                if (redirect) pc_d = target;
                else          pc_d = pc_q;
                if (bus.ifetch_rvalid) state_d = FETCH_REQ;
                else                   state_d = FETCH_DROP;
            end
            FETCH_HOLD: begin
                if (redirect) begin
                    inst_valid_d = 1'b0;
                    pc_d         = target;
                    state_d      = FETCH_REQ;
                end else if (!if2id_stall_i) begin
                    inst_valid_d = 1'b0;
                    pc_d         = pc_q + XLEN'(PC_STEP);
                    state_d      = FETCH_REQ;
                end else begin
                    state_d = FETCH_HOLD;
                end
            end
            default: begin
                state_d      = FETCH_BOOT;
                pc_d         = BOOT_PC;
                inst_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH_BOOT;
            pc_q         <= BOOT_PC;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0000_0000;
            inst_pc_q    <= BOOT_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign bus.ifetch_req   = (state_q == FETCH_REQ);
    assign bus.ifetch_addr  = pc_q;
    assign if_inst_valid_o  = inst_valid_q;
    assign if_inst_o        = inst_q;
    assign if_pc_o          = inst_pc_q;
endmodule
